// File: rtl/mem_arbiter_pkg.sv
// Shared processor package: memory-arbiter defaults, state encoding and a
// small state-classification helper used by the arbiter.
package mem_arbiter_pkg;

   localparam int DEF_BLOCK_WORDS = 8;    // 16-bit words per cache block
   localparam int DEF_ADDR_WIDTH  = 16;   // byte-address width
   localparam int WORD_WIDTH      = 16;

   // Arbiter states, kept as plain constants for legacy tools.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_IFILL  = 3'd1;
   localparam logic [2:0] ST_DFILL  = 3'd2;
   localparam logic [2:0] ST_DWRITE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // Which requester owns the operation currently in flight.
   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   // True for the two block-fill states.
   function automatic logic is_fill(input logic [2:0] st);
      return (st == ST_IFILL) || (st == ST_DFILL);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/memory bus of the memory arbiter.
//   slave  : the arbiter's view (takes cache requests, drives memory/fill side)
//   master : the environment's view (caches and memory model)
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH  = mem_arbiter_pkg::DEF_ADDR_WIDTH,
   parameter int BLOCK_WORDS = mem_arbiter_pkg::DEF_BLOCK_WORDS
);
   import mem_arbiter_pkg::*;

   // Cache request side
   logic                           i_req;
   logic [ADDR_WIDTH-1:0]          i_addr;
   logic                           d_req;
   logic                           d_wr;
   logic [ADDR_WIDTH-1:0]          d_addr;
   logic [WORD_WIDTH-1:0]          d_wdata;

   // Memory side
   logic                           mem_enable;
   logic                           mem_wr;
   logic [ADDR_WIDTH-1:0]          mem_addr;
   logic [WORD_WIDTH-1:0]          mem_wdata;
   logic [WORD_WIDTH-1:0]          mem_rdata;
   logic                           mem_valid;

   // Cache fill / completion side
   logic [$clog2(BLOCK_WORDS)-1:0] fill_word;
   logic [WORD_WIDTH-1:0]          fill_data;
   logic                           i_fill_we;
   logic                           d_fill_we;
   logic                           i_done;
   logic                           d_done;
   logic                           busy;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
      output mem_enable, mem_wr, mem_addr, mem_wdata,
             fill_word, fill_data, i_fill_we, d_fill_we, i_done, d_done, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
      input  mem_enable, mem_wr, mem_addr, mem_wdata,
             fill_word, fill_data, i_fill_we, d_fill_we, i_done, d_done, busy
   );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction-cache block fills,
// data-cache block fills and data-side single-word write-throughs. The data
// side wins when both ask in the same IDLE cycle. Fill reads are issued
// back-to-back; returns are counted separately because memory latency is
// unknown, and the operation completes once the last word is written.
module mem_arbiter #(
   parameter int BLOCK_WORDS = mem_arbiter_pkg::DEF_BLOCK_WORDS,
   parameter int ADDR_WIDTH  = mem_arbiter_pkg::DEF_ADDR_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);
   import mem_arbiter_pkg::*;

   localparam int IW  = $clog2(BLOCK_WORDS);
   localparam int IW1 = IW + 1;
   localparam int OFF = IW + 1;   // byte-offset bits inside one block
   localparam logic [IW:0]   ISSUE_END = IW1'(BLOCK_WORDS);
   localparam logic [IW-1:0] RET_LAST  = IW'(BLOCK_WORDS - 1);

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
   owner_e                owner_q, owner_d;
   logic [IW:0]           issue_cnt_q, issue_cnt_d;
   logic [IW-1:0]         ret_cnt_q, ret_cnt_d;

   logic                  in_fill;
   logic                  issue_active;

   logic                  mem_enable;
   logic                  mem_wr;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic [WORD_WIDTH-1:0] fill_data;
   logic                  i_fill_we;
   logic                  d_fill_we;
   logic                  i_done;
   logic                  d_done;

   assign in_fill      = is_fill(state_q);
   assign issue_active = in_fill && (issue_cnt_q != ISSUE_END);

   // Next-state logic: grant in IDLE, issue/return counting in the fill states.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      owner_d     = owner_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.d_req) begin
               addr_d      = bus.d_addr;
               wdata_d     = bus.d_wdata;
               owner_d     = OWNER_D;
               issue_cnt_d = '0;
               ret_cnt_d   = '0;
               state_d     = bus.d_wr ? ST_DWRITE : ST_DFILL;
            end else if (bus.i_req) begin
               addr_d      = bus.i_addr;
               wdata_d     = '0;
               owner_d     = OWNER_I;
               issue_cnt_d = '0;
               ret_cnt_d   = '0;
               state_d     = ST_IFILL;
            end
         end

         ST_IFILL, ST_DFILL: begin
            if (issue_active) begin
               issue_cnt_d = issue_cnt_q + IW1'(1);
            end
            if (bus.mem_valid) begin
               ret_cnt_d = ret_cnt_q + IW'(1);   // wraps to 0 after the last word
               if (ret_cnt_q == RET_LAST) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DWRITE: state_d = ST_DONE;

         ST_DONE: begin
            issue_cnt_d = '0;
            state_d     = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and latched-request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every flop here is reset; the block holds no storage array that could skip it.
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         owner_q     <= OWNER_I;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         owner_q     <= owner_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   // Memory strobes, fill strobes and completion pulses decoded from state.
   always_comb begin
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      fill_data  = '0;
      i_fill_we  = 1'b0;
      d_fill_we  = 1'b0;
      i_done     = 1'b0;
      d_done     = 1'b0;

      if (issue_active) begin
         mem_enable = 1'b1;
         mem_addr   = {addr_q[ADDR_WIDTH-1:OFF], issue_cnt_q[IW-1:0], 1'b0};
      end else if (state_q == ST_DWRITE) begin
         mem_enable = 1'b1;
         mem_wr     = 1'b1;
         mem_addr   = addr_q;
         mem_wdata  = wdata_q;
      end

      // Fill data is only passed through while a fill can consume it, so it
      // reads as zero in reset and in the non-fill states.
      if (in_fill) begin
         fill_data = bus.mem_rdata;
         i_fill_we = bus.mem_valid && (state_q == ST_IFILL);
         d_fill_we = bus.mem_valid && (state_q == ST_DFILL);
      end

      if (state_q == ST_DONE) begin
         i_done = (owner_q == OWNER_I);
         d_done = (owner_q == OWNER_D);
      end
   end

   assign bus.mem_enable = mem_enable;
   assign bus.mem_wr     = mem_wr;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.fill_word  = ret_cnt_q;
   assign bus.fill_data  = fill_data;
   assign bus.i_fill_we  = i_fill_we;
   assign bus.d_fill_we  = d_fill_we;
   assign bus.i_done     = i_done;
   assign bus.d_done     = d_done;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 8: 16-bit words per cache block; fixed, power of two.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: byte-address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  instruction-cache miss; held high until i_done.
REQ-006 i_addr  input  ADDR_WIDTH  instruction miss byte address.
REQ-007 d_req  input  1  data-side request; held high until d_done.
REQ-008 d_wr  input  1  with d_req: 1 = single-word write-through, 0 = block fill.
REQ-009 d_addr  input  ADDR_WIDTH  data byte address.
REQ-010 d_wdata  input  16  write-through data.
REQ-011 mem_enable  output  1  memory access strobe, one access per cycle.
REQ-012 mem_wr  output  1  memory write select.
REQ-013 mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-014 mem_wdata  output  16  memory write data.
REQ-015 mem_rdata  input  16  memory read data, qualified by mem_valid.
REQ-016 mem_valid  input  1  read data returning, fixed unknown latency >= 1, in issue order.
REQ-017 fill_word  output  log2(BLOCK_WORDS)  word index of current fill write.
REQ-018 fill_data  output  16  equals mem_rdata.
REQ-019 i_fill_we / d_fill_we  output  1 each  cache fill write strobes.
REQ-020 i_done / d_done  output  1 each  one-cycle completion pulses.
REQ-021 busy  output  1  high whenever state != IDLE.

Function
REQ-022 SHALL implement states IDLE, IFILL, DFILL, DWRITE, DONE.
REQ-023 In IDLE: d_req has fixed priority over i_req; d_req&d_wr -> DWRITE; d_req&~d_wr -> DFILL; else i_req -> IFILL; none -> stay.
REQ-024 On grant SHALL latch block base = addr[ADDR_WIDTH-1:4] (d_addr or i_addr) and write address/data; inputs ignored thereafter until IDLE.
REQ-025 Fill states SHALL issue BLOCK_WORDS reads on consecutive cycles starting the cycle after grant: mem_enable=1, mem_wr=0, mem_addr={base, issue_cnt, 1'b0}, issue_cnt 0..BLOCK_WORDS-1; mem_enable=0 after last issue.
REQ-026 Fill states SHALL count returns with separate ret_cnt; each mem_valid cycle asserts i_fill_we (IFILL) or d_fill_we (DFILL) with fill_word=ret_cnt, then ret_cnt increments.
REQ-027 After ret_cnt wraps from BLOCK_WORDS-1 (last word written) SHALL go to DONE next cycle.
REQ-028 DWRITE SHALL last exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=latched d_addr, mem_wdata=latched d_wdata; then DONE.
REQ-029 DONE SHALL last one cycle, pulse i_done (after IFILL) or d_done (after DFILL/DWRITE), grant nothing, then return to IDLE.
REQ-030 Requester SHALL drop req in its done cycle; a req still high in the following IDLE is a new request.
REQ-031 mem_valid in IDLE, DWRITE or DONE SHALL be ignored: no fill strobe, no counter change.
REQ-032 Requests dropped mid-operation SHALL NOT abort it; operation runs to DONE.
REQ-033 i_fill_we and d_fill_we SHALL never be high together; mem_wr SHALL be high only in DWRITE.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, counters 0, latched address 0, and all outputs 0 (mem_addr, mem_wdata, fill_word included).
REQ-035 Reset mid-fill SHALL discard the fill; no done pulse; outstanding mem_valid after release ignored per REQ-031.

Structure
REQ-036 State encoding and BLOCK_WORDS default SHALL live in the shared processor package.
REQ-037 SHALL be one flat module; no sub-module.

Verification (memory model latency 4)
REQ-038 i_req, i_addr=0x1236 -> reads 0x1230..0x123E on 8 consecutive cycles; i_fill_we words 0..7 four cycles behind; i_done one cycle after word 7; busy low next cycle.
REQ-039 i_req and d_req (d_wr=0, d_addr=0x4000) same cycle -> DFILL 0x4000..0x400E first, d_done, then IFILL; no overlap of strobes.
REQ-040 d_req, d_wr=1, d_addr=0x00A4, d_wdata=0xBEEF -> single cycle mem_enable=1, mem_wr=1, addr 0x00A4, data 0xBEEF; d_done next cycle.
REQ-041 rst_n low after 3rd fill word -> all outputs 0 immediately; late mem_valid pulses produce no fill_we; next i_req refills from word 0.
REQ-042 Spurious mem_valid in IDLE and i_req dropped mid-fill -> no fill strobes in IDLE; fill completes with i_done.
